// File: rtl/shared_mem_pkg.sv
// Shared-memory family package: write/write collision policy codes and the
// byte-enable merge used wherever a partial write meets existing data.
package shared_mem_pkg;

    localparam int COLL_A_WINS = 0;
    localparam int COLL_B_WINS = 1;
    localparam int COLL_RR     = 2;

    // Widest word any shared-memory block may use; callers size-cast in and out.
    localparam int MERGE_MAX_W  = 256;
    localparam int MERGE_MAX_NB = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_NB-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_MAX_NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Plain true dual-port storage with per-byte write enables and a registered
// read; read returns the contents from before any same-edge write.
module dp_ram_core #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [NB-1:0]     be_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              re_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              we_b,
    input  logic [NB-1:0]     be_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              re_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte enables arrive already disjoint on a shared address, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
            if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[addr_a];
            if (re_b) rdata_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/dp_ram_arb_be.sv
// Dual-port shared RAM front end: byte-accurate collision resolve, write-first
// forwarding across ports, valid-tagged read pipeline and a collision counter.
module dp_ram_arb_be
    import shared_mem_pkg::*;
#(
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int READ_LAT         = 1,
    parameter int COLL_POLICY      = 0,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_a,
    input  logic                        we_a,
    input  logic [DATA_WIDTH/8-1:0]     be_a,
    input  logic [LOCAL_ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]       wdata_a,
    output logic [DATA_WIDTH-1:0]       rdata_a,
    output logic                        rvalid_a,
    input  logic                        req_b,
    input  logic                        we_b,
    input  logic [DATA_WIDTH/8-1:0]     be_b,
    input  logic [LOCAL_ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]       wdata_b,
    output logic [DATA_WIDTH-1:0]       rdata_b,
    output logic                        rvalid_b,
    output logic [CNT_WIDTH-1:0]        coll_cnt
);

    localparam int                   NB      = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [DATA_WIDTH-1:0] fwd_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        return DATA_WIDTH'(merge_be(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                    MERGE_MAX_NB'(be)));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    logic              rd_a, rd_b, wr_a, wr_b, same_addr, coll, prio_a, rr_ptr;
    logic [NB-1:0]     overlap, be_a_eff, be_b_eff, fwd_be_a, fwd_be_b;
    logic [DATA_WIDTH-1:0] core_rdata_a, core_rdata_b, rd_word_a, rd_word_b;

    // A write with no enabled byte is treated as no access at all.
    assign rd_a      = req_a & ~we_a;
    assign rd_b      = req_b & ~we_b;
    assign wr_a      = req_a & we_a & (|be_a);
    assign wr_b      = req_b & we_b & (|be_b);
    assign same_addr = (addr_a == addr_b);
    assign coll      = wr_a & wr_b & same_addr;
    assign overlap   = be_a & be_b;
    assign prio_a    = (COLL_POLICY == COLL_A_WINS) ||
                       ((COLL_POLICY == COLL_RR) && !rr_ptr);
    assign be_a_eff  = (coll && !prio_a) ? (be_a & ~overlap) : be_a;
    assign be_b_eff  = (coll &&  prio_a) ? (be_b & ~overlap) : be_b;
    assign fwd_be_a  = (rd_a && wr_b && same_addr) ? be_b : '0;
    assign fwd_be_b  = (rd_b && wr_a && same_addr) ? be_a : '0;

    dp_ram_core #(
        .ADDR_W (LOCAL_ADDR_WIDTH),
        .DATA_W (DATA_WIDTH),
        .NB     (NB)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we_a    (wr_a),
        .be_a    (be_a_eff),
        .addr_a  (addr_a),
        .wdata_a (wdata_a),
        .re_a    (rd_a),
        .rdata_a (core_rdata_a),
        .we_b    (wr_b),
        .be_b    (be_b_eff),
        .addr_b  (addr_b),
        .wdata_b (wdata_b),
        .re_b    (rd_b),
        .rdata_b (core_rdata_b)
    );

    // Stage p0: read issued; forwarding info captured alongside the core read register
    logic              vld_a_p0, vld_b_p0;
    logic [NB-1:0]     fwd_be_a_p0, fwd_be_b_p0;
    logic [DATA_WIDTH-1:0] fwd_data_a_p0, fwd_data_b_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a_p0    <= 1'b0;
            vld_b_p0    <= 1'b0;
            fwd_be_a_p0 <= '0;
            fwd_be_b_p0 <= '0;
            rr_ptr      <= 1'b0;
            coll_cnt    <= '0;
        end else begin
            vld_a_p0 <= rd_a;
            vld_b_p0 <= rd_b;
            if (rd_a) fwd_be_a_p0 <= fwd_be_a;
            if (rd_b) fwd_be_b_p0 <= fwd_be_b;
            if (coll) coll_cnt <= sat_inc(coll_cnt);
            if ((COLL_POLICY == COLL_RR) && coll && (|overlap)) rr_ptr <= ~rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_a) fwd_data_a_p0 <= wdata_b;
        if (rd_b) fwd_data_b_p0 <= wdata_a;
    end

    assign rd_word_a = fwd_merge(core_rdata_a, fwd_data_a_p0, fwd_be_a_p0);
    assign rd_word_b = fwd_merge(core_rdata_b, fwd_data_b_p0, fwd_be_b_p0);

    // Stage p1: optional output register
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              vld_a_p1, vld_b_p1;
            logic [DATA_WIDTH-1:0] rdata_a_p1, rdata_b_p1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_a_p1   <= 1'b0;
                    vld_b_p1   <= 1'b0;
                    rdata_a_p1 <= '0;
                    rdata_b_p1 <= '0;
                end else begin
                    vld_a_p1 <= vld_a_p0;
                    vld_b_p1 <= vld_b_p0;
                    if (vld_a_p0) rdata_a_p1 <= rd_word_a;
                    if (vld_b_p0) rdata_b_p1 <= rd_word_b;
                end
            end

            assign rdata_a  = rdata_a_p1;
            assign rdata_b  = rdata_b_p1;
            assign rvalid_a = vld_a_p1;
            assign rvalid_b = vld_b_p1;
        end else begin : g_lat1
            assign rdata_a  = rd_word_a;
            assign rdata_b  = rd_word_b;
            assign rvalid_a = vld_a_p0;
            assign rvalid_b = vld_b_p0;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_arb_be.sv
// Bench for dp_ram_arb_be: two instances (latency 1 / A wins / 16-bit counter and
// latency 2 / round-robin / 2-bit counter) share stimulus; a byte-level model feeds scoreboards.
module tb_dp_ram_arb_be;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req_a, we_a, req_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [DW-1:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic          rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic [15:0]   coll_cnt0;
    logic [1:0]    coll_cnt1;

    dp_ram_arb_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1),
                    .COLL_POLICY(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .coll_cnt(coll_cnt0));

    dp_ram_arb_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2),
                    .COLL_POLICY(2), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .coll_cnt(coll_cnt1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q0a[$], q0b[$], q1a[$], q1b[$];
    logic [DW-1:0] m0 [1 << AW];
    logic [DW-1:0] m1 [1 << AW];
    logic [DW-1:0] last [4];
    int            cnt0 = 0, cnt1 = 0;
    bit            rr1 = 1'b0;
    bit            mon_on = 1'b0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int d, input logic [AW-1:0] a);
        return (d == 0) ? m0[a] : m1[a];
    endfunction

    task automatic mem_wr(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (d == 0) m0[a] = v;
        else        m1[a] = v;
    endtask

    task automatic push(input int idx, input logic [DW-1:0] v);
        exp_t e;
        e.data = v;
        e.cyc  = cyc + ((idx < 2) ? 1 : 2);
        case (idx)
            0: q0a.push_back(e);
            1: q0b.push_back(e);
            2: q1a.push_back(e);
            default: q1b.push_back(e);
        endcase
    endtask

    task automatic pop(input int idx, output exp_t e, output bit ok);
        ok = 1'b1;
        e.data = '0;
        e.cyc  = 0;
        case (idx)
            0: if (q0a.size() == 0) ok = 1'b0; else e = q0a.pop_front();
            1: if (q0b.size() == 0) ok = 1'b0; else e = q0b.pop_front();
            2: if (q1a.size() == 0) ok = 1'b0; else e = q1a.pop_front();
            default: if (q1b.size() == 0) ok = 1'b0; else e = q1b.pop_front();
        endcase
    endtask

    // Applies the current port inputs to both reference memories for one edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [DW-1:0] v;
            bit wa, wb, coll, pa;
            wa = req_a && we_a;
            wb = req_b && we_b;
            if (req_a && !we_a) begin
                v = mem_rd(d, addr_a);
                if (wb && addr_b == addr_a) v = merge(v, wdata_b, be_b);
                push(2*d, v);
            end
            if (req_b && !we_b) begin
                v = mem_rd(d, addr_b);
                if (wa && addr_a == addr_b) v = merge(v, wdata_a, be_a);
                push(2*d + 1, v);
            end
            coll = wa && wb && (addr_a == addr_b) && (be_a != 0) && (be_b != 0);
            pa   = (d == 0) ? 1'b1 : !rr1;
            if (wa) mem_wr(d, addr_a, merge(mem_rd(d, addr_a), wdata_a, be_a));
            if (wb) mem_wr(d, addr_b, merge(mem_rd(d, addr_b), wdata_b,
                                            (coll && pa) ? (be_b & ~be_a) : be_b));
            if (coll) begin
                if (d == 0) cnt0 = (cnt0 < 65535) ? cnt0 + 1 : cnt0;
                else begin
                    cnt1 = (cnt1 < 3) ? cnt1 + 1 : cnt1;
                    if ((be_a & be_b) != 0) rr1 = !rr1;
                end
            end
        end
    endtask

    task automatic mon(input int idx, input logic rv, input logic [DW-1:0] rd);
        exp_t e;
        bit   ok;
        if (rv) begin
            pop(idx, e, ok);
            if (!ok) check($sformatf("spurious_rvalid%0d", idx), 64'd1, 64'd0);
            else begin
                check($sformatf("latency%0d", idx), 64'(cyc), 64'(e.cyc));
                check($sformatf("rdata%0d", idx), 64'(rd), 64'(e.data));
                last[idx] = e.data;
            end
        end else begin
            check($sformatf("hold%0d", idx), 64'(rd), 64'(last[idx]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            mon(0, rvalid_a0, rdata_a0);
            mon(1, rvalid_b0, rdata_b0);
            mon(2, rvalid_a1, rdata_a1);
            mon(3, rvalid_b1, rdata_b1);
            check("coll_cnt0", 64'(coll_cnt0), 64'(cnt0));
            check("coll_cnt1", 64'(coll_cnt1), 64'(cnt1));
        end
    end

    task automatic set_a(input bit r, input bit w, input logic [NB-1:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        req_a = r; we_a = w; be_a = be; addr_a = ad; wdata_a = d;
    endtask

    task automatic set_b(input bit r, input bit w, input logic [NB-1:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        req_b = r; we_b = w; be_b = be; addr_b = ad; wdata_b = d;
    endtask

    task automatic idle();
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
        for (int i = 0; i < 4; i++) last[i] = '0;
        cnt0 = 0; cnt1 = 0; rr1 = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        for (int i = 0; i < 4; i++) last[i] = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rvalid_a0", 64'(rvalid_a0), 64'd0);
        check("rst_rvalid_b0", 64'(rvalid_b0), 64'd0);
        check("rst_rvalid_a1", 64'(rvalid_a1), 64'd0);
        check("rst_rvalid_b1", 64'(rvalid_b1), 64'd0);
        check("rst_rdata_a0", 64'(rdata_a0), 64'd0);
        check("rst_rdata_b1", 64'(rdata_b1), 64'd0);
        check("rst_coll_cnt0", 64'(coll_cnt0), 64'd0);
        check("rst_coll_cnt1", 64'(coll_cnt1), 64'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Write then read on the other port.
        set_a(1, 1, 4'hF, 10'h03F, 32'hDEADBEEF); step();
        idle(); set_b(1, 0, '0, 10'h03F, '0); step();
        idle(); step();

        // Partial write forwarded to a same-cycle read on the other port.
        set_a(1, 1, 4'hF, 10'h040, 32'h11223344); step();
        set_a(1, 1, 4'b0011, 10'h040, 32'hA5A50001); set_b(1, 0, '0, 10'h040, '0); step();
        set_a(1, 0, '0, 10'h040, '0); set_b(1, 0, '0, 10'h040, '0); step();

        // Full collision at 0x055, then read back on both ports.
        set_a(1, 1, 4'hF, 10'h055, 32'hAAAA5555); set_b(1, 1, 4'hF, 10'h055, 32'hBBBB5555); step();
        set_a(1, 0, '0, 10'h055, '0); set_b(1, 0, '0, 10'h055, '0); step();
        idle(); step(); step();

        // Round-robin sequence from a fresh pointer.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_a(1, 1, 4'hF, 10'h060, 32'hAAAA0000 + i);
            set_b(1, 1, 4'hF, 10'h060, 32'hBBBB0000 + i);
            step();
        end
        idle(); set_a(1, 0, '0, 10'h060, '0); step();
        set_a(1, 1, 4'b1100, 10'h061, 32'hAAAAAAAA); set_b(1, 1, 4'b0011, 10'h061, 32'h55555555); step();
        idle(); set_b(1, 0, '0, 10'h061, '0); step();
        set_a(1, 1, 4'hF, 10'h060, 32'hAAAA00FF); set_b(1, 1, 4'hF, 10'h060, 32'hBBBB00FF); step();
        idle(); set_a(1, 0, '0, 10'h060, '0); step();
        set_a(1, 1, 4'h0, 10'h060, 32'h12345678); set_b(1, 1, 4'h0, 10'h060, 32'h87654321); step();
        idle(); set_b(1, 0, '0, 10'h060, '0); step();
        idle(); step(); step();

        // Preload a small window, then a read stream with a reset in the middle.
        for (int i = 0; i < 16; i += 2) begin
            set_a(1, 1, 4'hF, AW'(i), $urandom);
            set_b(1, 1, 4'hF, AW'(i + 1), $urandom);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 6) do_reset();
            set_a(1, 0, '0, AW'($urandom_range(0, 15)), '0);
            set_b(1, 0, '0, AW'($urandom_range(0, 15)), '0);
            step();
        end

        // Random mixed traffic over a narrow window to provoke collisions and forwarding.
        for (int i = 0; i < 80; i++) begin
            set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), NB'($urandom),
                  AW'($urandom_range(0, 7)), $urandom);
            set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), NB'($urandom),
                  AW'($urandom_range(0, 7)), $urandom);
            step();
        end

        idle();
        repeat (6) step();
        check("drain_q0a", 64'(q0a.size()), 64'd0);
        check("drain_q0b", 64'(q0b.size()), 64'd0);
        check("drain_q1a", 64'(q1a.size()), 64'd0);
        check("drain_q1b", 64'(q1b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
